// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: PC and pipeline-register enables plus NOP selects.
// Latency: all control outputs are combinational from the current state and same-cycle inputs; state updates on i_clk.
// Backpressure: i_mem_stall freezes every stage and the FSM; a load-use hazard holds PC and IF/ID for one cycle and bubbles ID/EX.
//
// Ports:
//   i_clk, i_rst_n                  clock (rising edge), asynchronous active-low reset
//   i_mem_stall                     I- or D-memory busy this cycle
//   i_br_taken                      branch/jump in EX resolved taken
//   i_ex_memread, i_ex_rd           EX instruction is a load, and its destination
//   i_id_rs, i_id_rt, i_id_uses_rt  ID source registers, and whether rt is actually read
//   i_id_halt                       ID instruction is HLT
//   o_pc_en, o_en_*                 PC and pipeline-register write enables
//   o_flush_ifid, o_bubble_idex     NOP select into IF/ID and ID/EX
//   o_halted, o_state               drained-after-HLT flag, FSM state (debug)
// Optional: define PIPE_CTRL_PERF_EN to add saturating o_stall_cnt / o_flush_cnt counters.

module pipeline_ctrl #(
    parameter int REG_W        = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_mem_stall,
    input  logic             i_br_taken,
    input  logic             i_ex_memread,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_uses_rt,
    input  logic             i_id_halt,
    output logic             o_pc_en,
    output logic             o_en_ifid,
    output logic             o_en_idex,
    output logic             o_en_exmem,
    output logic             o_en_memwb,
    output logic             o_flush_ifid,
    output logic             o_bubble_idex,
    output logic             o_halted,
    output logic [1:0]       o_state
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [15:0]      o_stall_cnt,
    output logic [15:0]      o_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam int                CNT_W      = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0]  DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic w_load_use;
    logic w_pc_en;
    logic w_en_ifid;
    logic w_en_idex;
    logic w_en_exmem;
    logic w_en_memwb;
    logic w_flush;
    logic w_bubble;

    // r0 is hardwired zero, so a load targeting it can never create a real dependency.
    assign w_load_use = i_ex_memread && (i_ex_rd != '0) &&
                        ((i_ex_rd == i_id_rs) || (i_id_uses_rt && (i_ex_rd == i_id_rt)));

    // While reset is held the pipeline registers are themselves in reset, so the
    // enables are left open rather than reflecting hazards on undefined inputs.
    always_comb begin
        w_pc_en    = 1'b1;
        w_en_ifid  = 1'b1;
        w_en_idex  = 1'b1;
        w_en_exmem = 1'b1;
        w_en_memwb = 1'b1;
        w_flush    = 1'b0;
        w_bubble   = 1'b0;
        if (i_rst_n) begin
            case (r_state)
                ST_RUN: begin
                    if (i_mem_stall) begin
                        w_pc_en    = 1'b0;
                        w_en_ifid  = 1'b0;
                        w_en_idex  = 1'b0;
                        w_en_exmem = 1'b0;
                        w_en_memwb = 1'b0;
                    end else if (i_br_taken) begin
                        // A taken branch squashes both younger instructions, including any HLT in ID.
                        w_flush  = 1'b1;
                        w_bubble = 1'b1;
                    end else if (w_load_use) begin
                        w_pc_en   = 1'b0;
                        w_en_ifid = 1'b0;
                        w_bubble  = 1'b1;
                    end else if (i_id_halt) begin
                        // HLT itself moves on into EX; nothing younger is admitted.
                        w_pc_en   = 1'b0;
                        w_en_ifid = 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (i_mem_stall) begin
                        w_pc_en    = 1'b0;
                        w_en_ifid  = 1'b0;
                        w_en_idex  = 1'b0;
                        w_en_exmem = 1'b0;
                        w_en_memwb = 1'b0;
                    end else begin
                        w_pc_en   = 1'b0;
                        w_en_ifid = 1'b0;
                        w_bubble  = 1'b1;
                    end
                end
                ST_HALTED: begin
                    w_pc_en    = 1'b0;
                    w_en_ifid  = 1'b0;
                    w_en_idex  = 1'b0;
                    w_en_exmem = 1'b0;
                    w_en_memwb = 1'b0;
                end
                default: begin
                    // Unused encoding behaves like RUN with no hazards for its single cycle.
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!i_mem_stall && !i_br_taken && !w_load_use && i_id_halt) begin
                        r_state <= ST_DRAIN;
                        r_cnt   <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (!i_mem_stall) begin
                        r_cnt <= r_cnt - CNT_ONE;
                        // Leaving on the last decrement: HLT retires from WB this cycle.
                        if (r_cnt <= CNT_ONE) begin
                            r_state <= ST_HALTED;
                        end
                    end
                end
                ST_HALTED: begin
                    r_state <= ST_HALTED;
                end
                default: begin
                    r_state <= ST_RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_pc_en && ((r_state == ST_RUN) || (r_state == ST_DRAIN)) &&
                (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_flush && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
`endif

    assign o_pc_en       = w_pc_en;
    assign o_en_ifid     = w_en_ifid;
    assign o_en_idex     = w_en_idex;
    assign o_en_exmem    = w_en_exmem;
    assign o_en_memwb    = w_en_memwb;
    assign o_flush_ifid  = w_flush;
    assign o_bubble_idex = w_bubble;
    assign o_halted      = (r_state == ST_HALTED);
    assign o_state       = r_state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: vector table, hand-written multi-cycle sequences, randomized run against a reference model.
// Inputs are driven 1 time unit after the rising edge; outputs are compared a few units later, before the next edge.
// Control vectors are packed as {pc_en, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, bubble_idex}.

module tb_pipeline_ctrl;

    localparam int REG_W = 4;
    localparam int DC    = 3;

    localparam logic [6:0] C_OPEN   = 7'b1111100;
    localparam logic [6:0] C_FREEZE = 7'b0000000;
    localparam logic [6:0] C_BRANCH = 7'b1111111;
    localparam logic [6:0] C_LDUSE  = 7'b0011101;
    localparam logic [6:0] C_HLT    = 7'b0011100;
    localparam logic [6:0] C_DRAIN  = 7'b0011101;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             mem_stall, br_taken, ex_memread, id_uses_rt, id_halt;
    logic [REG_W-1:0] ex_rd, id_rs, id_rt;
    logic             pc_en, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, bubble_idex, halted;
    logic [1:0]       state;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0]      stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    pipeline_ctrl #(.REG_W(REG_W), .DRAIN_CYCLES(DC)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_mem_stall  (mem_stall),
        .i_br_taken   (br_taken),
        .i_ex_memread (ex_memread),
        .i_ex_rd      (ex_rd),
        .i_id_rs      (id_rs),
        .i_id_rt      (id_rt),
        .i_id_uses_rt (id_uses_rt),
        .i_id_halt    (id_halt),
        .o_pc_en      (pc_en),
        .o_en_ifid    (en_ifid),
        .o_en_idex    (en_idex),
        .o_en_exmem   (en_exmem),
        .o_en_memwb   (en_memwb),
        .o_flush_ifid (flush_ifid),
        .o_bubble_idex(bubble_idex),
        .o_halted     (halted),
        .o_state      (state)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .o_stall_cnt  (stall_cnt),
        .o_flush_cnt  (flush_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ctrl();
        return {pc_en, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, bubble_idex};
    endfunction

    task automatic drive(input logic ms, input logic br, input logic mr, input logic [REG_W-1:0] rd,
                         input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt, input logic urt,
                         input logic hlt);
        mem_stall = ms; br_taken = br; ex_memread = mr; ex_rd = rd;
        id_rs = rs; id_rt = rt; id_uses_rt = urt; id_halt = hlt;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    // Expected control word from the priority rules; drain_left: -1 running, >0 draining, 0 halted.
    function automatic logic [6:0] model_ctrl(input int drain_left, input logic ms, input logic br,
                                              input logic lu, input logic hlt);
        if (drain_left == 0) return C_FREEZE;
        if (ms)              return C_FREEZE;
        if (drain_left > 0)  return C_DRAIN;
        if (br)              return C_BRANCH;
        if (lu)              return C_LDUSE;
        if (hlt)             return C_HLT;
        return C_OPEN;
    endfunction

    typedef struct packed {
        logic             ms;
        logic             br;
        logic             mr;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             urt;
        logic             hlt;
        logic [6:0]       exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int drain_left;
        int m_stall, m_flush;
        logic lu;
        logic [6:0] e;

        //            ms  br  mr  rd  rs  rt  urt hlt expected
        tbl[0]  = '{1'b0,1'b0,1'b0,4'd0, 4'd1, 4'd2, 1'b1,1'b0, C_OPEN};
        tbl[1]  = '{1'b0,1'b0,1'b1,4'd3, 4'd3, 4'd5, 1'b0,1'b0, C_LDUSE};
        tbl[2]  = '{1'b0,1'b0,1'b1,4'd0, 4'd0, 4'd0, 1'b1,1'b0, C_OPEN};
        tbl[3]  = '{1'b0,1'b0,1'b1,4'd7, 4'd1, 4'd7, 1'b0,1'b0, C_OPEN};
        tbl[4]  = '{1'b0,1'b0,1'b1,4'd7, 4'd1, 4'd7, 1'b1,1'b0, C_LDUSE};
        tbl[5]  = '{1'b0,1'b1,1'b1,4'd3, 4'd3, 4'd0, 1'b0,1'b0, C_BRANCH};
        tbl[6]  = '{1'b1,1'b1,1'b1,4'd3, 4'd3, 4'd0, 1'b0,1'b0, C_FREEZE};
        tbl[7]  = '{1'b0,1'b0,1'b0,4'd3, 4'd3, 4'd3, 1'b1,1'b0, C_OPEN};
        tbl[8]  = '{1'b0,1'b1,1'b0,4'd0, 4'd1, 4'd2, 1'b0,1'b1, C_BRANCH};
        tbl[9]  = '{1'b0,1'b0,1'b1,4'd2, 4'd2, 4'd0, 1'b0,1'b1, C_LDUSE};
        tbl[10] = '{1'b1,1'b0,1'b0,4'd0, 4'd1, 4'd2, 1'b0,1'b1, C_FREEZE};
        tbl[11] = '{1'b0,1'b0,1'b1,4'd15,4'd15,4'd0, 1'b0,1'b0, C_LDUSE};

        // Reset state: stall conditions on the inputs must not leak through while reset is held.
        rst_n = 1'b0;
        drive(1, 0, 1, 3, 3, 0, 0, 1);
        #3;
        chk("reset_ctrl", 16'(ctrl()), 16'(C_OPEN));
        chk("reset_state", 16'(state), 16'd0);
        chk("reset_halted", 16'(halted), 16'd0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        next_cycle();

        // Single-cycle priority vectors; none of them may leave RUN.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].ms, tbl[i].br, tbl[i].mr, tbl[i].rd, tbl[i].rs, tbl[i].rt, tbl[i].urt, tbl[i].hlt);
            #2;
            chk($sformatf("tbl%0d_ctrl", i), 16'(ctrl()), 16'(tbl[i].exp));
            chk($sformatf("tbl%0d_state", i), 16'(state), 16'd0);
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("tbl_end_state", 16'(state), 16'd0);
        next_cycle();

        // Memory stall over a load-use hazard: 4 frozen cycles, then exactly one load-use cycle.
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 1, 3, 3, 0, 0, 0);
            #2;
            chk($sformatf("mstall%0d_ctrl", k), 16'(ctrl()), 16'(C_FREEZE));
            next_cycle();
        end
        drive(0, 0, 1, 3, 3, 0, 0, 0);
        #2;
        chk("mstall_lduse_ctrl", 16'(ctrl()), 16'(C_LDUSE));
        next_cycle();
        drive(0, 0, 0, 3, 3, 0, 0, 0);
        #2;
        chk("mstall_after_ctrl", 16'(ctrl()), 16'(C_OPEN));
        next_cycle();

        // HLT drain with one memory stall inside it; branch and load-use are ignored while draining.
        drive(0, 0, 0, 0, 1, 2, 0, 1);
        #2;
        chk("hlt_ctrl", 16'(ctrl()), 16'(C_HLT));
        chk("hlt_state", 16'(state), 16'd0);
        next_cycle();
        for (int k = 0; k < DC + 1; k++) begin
            if (k == 1) drive(1, 0, 0, 0, 0, 0, 0, 0);
            else        drive(0, 1, 1, 3, 3, 0, 0, 0);
            #2;
            chk($sformatf("drain%0d_ctrl", k), 16'(ctrl()), 16'(k == 1 ? C_FREEZE : C_DRAIN));
            chk($sformatf("drain%0d_state", k), 16'(state), 16'd1);
            chk($sformatf("drain%0d_halted", k), 16'(halted), 16'd0);
            next_cycle();
        end
        drive(0, 1, 0, 0, 0, 0, 0, 1);
        #2;
        chk("halted_ctrl", 16'(ctrl()), 16'(C_FREEZE));
        chk("halted_state", 16'(state), 16'd2);
        chk("halted_flag", 16'(halted), 16'd1);
        next_cycle();
        #2;
        chk("halted_sticky", 16'(halted), 16'd1);

        // Reset asserted mid-DRAIN takes effect immediately.
        next_cycle();
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        next_cycle();
        drive(1, 0, 1, 3, 3, 0, 0, 0);
        #1;
        chk("mid_drain_state", 16'(state), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_drain_state", 16'(state), 16'd0);
        chk("rst_drain_halted", 16'(halted), 16'd0);
        chk("rst_drain_ctrl", 16'(ctrl()), 16'(C_OPEN));
        next_cycle();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();

`ifdef PIPE_CTRL_PERF_EN
        do_reset();
        #2;
        chk("perf_rst_stall", stall_cnt, 16'd0);
        chk("perf_rst_flush", flush_cnt, 16'd0);
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            if (k < 3) drive(0, 0, 1, 4'(k + 1), 4'(k + 1), 0, 0, 0);
            else       drive(0, 1, 0, 0, 0, 0, 0, 0);
            next_cycle();
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            next_cycle();
        end
        #2;
        chk("perf_stall_cnt", stall_cnt, 16'd3);
        chk("perf_flush_cnt", flush_cnt, 16'd2);
        next_cycle();
`endif

        // Randomized run against the reference model.
        do_reset();
        drain_left = -1;
        m_stall = 0;
        m_flush = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 149) == 0) begin
                rst_n = 1'b0;
                #1;
                chk("rnd_rst_state", 16'(state), 16'd0);
                chk("rnd_rst_ctrl", 16'(ctrl()), 16'(C_OPEN));
                rst_n = 1'b1;
                drain_left = -1;
                m_stall = 0;
                m_flush = 0;
            end
            drive($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 24) == 0);
            #1;
            lu = ex_memread && (ex_rd != 0) && ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
            e  = model_ctrl(drain_left, mem_stall, br_taken, lu, id_halt);
            chk("rnd_ctrl", 16'(ctrl()), 16'(e));
            chk("rnd_state", 16'(state), 16'(drain_left < 0 ? 0 : (drain_left > 0 ? 1 : 2)));
            chk("rnd_halted", 16'(halted), 16'(drain_left == 0));
            if (!e[6] && drain_left != 0 && m_stall < 65535) m_stall++;
            if (e[1] && m_flush < 65535) m_flush++;
            if (!mem_stall) begin
                if (drain_left < 0 && !br_taken && !lu && id_halt) drain_left = DC;
                else if (drain_left > 0) drain_left--;
            end
            next_cycle();
        end
`ifdef PIPE_CTRL_PERF_EN
        #2;
        chk("rnd_stall_cnt", stall_cnt, 16'(m_stall));
        chk("rnd_flush_cnt", flush_cnt, 16'(m_flush));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
